control_unit: RTL and testbench

Hardwired sequencer for the single-bus datapath (`Datapath2`). It fetches each instruction, decodes its opcode from IR, and drives the datapath's one-hot control strobes one step per clock to execute it. This replaces the hand-written state sequences in benches with a synthesizable controller. It sits beside `Datapath2`, which consumes every strobe port listed below.

---
 rtl/cpu_ctrl_pkg.sv | 86 ++++++++
 rtl/ctrl_decode.sv | 34 +++
 rtl/control_unit.sv | 183 ++++++++++++++++++
 tb/tb_control_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus datapath sequencer: opcodes, ALU codes,
// controller state and instruction-class enums, and the opcode-to-ALU mapping.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_AND  = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SHR  = 5'd5;
    localparam logic [4:0] ALU_SHRA = 5'd6;
    localparam logic [4:0] ALU_SHL  = 5'd7;
    localparam logic [4:0] ALU_ROR  = 5'd8;
    localparam logic [4:0] ALU_ROL  = 5'd9;
    localparam logic [4:0] ALU_NEG  = 5'd10;
    localparam logic [4:0] ALU_NOT  = 5'd11;
    localparam logic [4:0] ALU_INC  = 5'd12;

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_LD    = 4'd0,
        CL_LDI   = 4'd1,
        CL_ST    = 4'd2,
        CL_RALU  = 4'd3,
        CL_IALU  = 4'd4,
        CL_UNARY = 4'd5,
        CL_BR    = 4'd6,
        CL_JR    = 4'd7,
        CL_NOP   = 4'd8,
        CL_HALT  = 4'd9,
        CL_ILL   = 4'd10
    } iclass_t;

    // Immediate forms share the ALU function of their register counterparts.
    function automatic logic [4:0] alu_sel(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: alu_sel = ALU_ADD;
            OP_SUB:          alu_sel = ALU_SUB;
            OP_AND, OP_ANDI: alu_sel = ALU_AND;
            OP_OR, OP_ORI:   alu_sel = ALU_OR;
            OP_SHR:          alu_sel = ALU_SHR;
            OP_SHRA:         alu_sel = ALU_SHRA;
            OP_SHL:          alu_sel = ALU_SHL;
            OP_ROR:          alu_sel = ALU_ROR;
            OP_ROL:          alu_sel = ALU_ROL;
            OP_NEG:          alu_sel = ALU_NEG;
            OP_NOT:          alu_sel = ALU_NOT;
            default:         alu_sel = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class and the index of the
// last T-step that class executes before returning to fetch.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] i_op,
    output iclass_t    o_cls,
    output logic [2:0] o_last
);

    // Classify the opcode; anything unlisted is illegal and ends at T3.
    always_comb begin
        o_cls  = CL_ILL;
        o_last = 3'd3;
        case (i_op)
            OP_LD:   begin o_cls = CL_LD;   o_last = 3'd7; end
            OP_ST:   begin o_cls = CL_ST;   o_last = 3'd7; end
            OP_LDI:  begin o_cls = CL_LDI;  o_last = 3'd5; end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     begin o_cls = CL_RALU; o_last = 3'd5; end
            OP_ADDI, OP_ANDI, OP_ORI:
                     begin o_cls = CL_IALU; o_last = 3'd5; end
            OP_NEG, OP_NOT:
                     begin o_cls = CL_UNARY; o_last = 3'd4; end
            OP_BR:   begin o_cls = CL_BR;   o_last = 3'd6; end
            OP_JR:   begin o_cls = CL_JR;   o_last = 3'd3; end
            OP_NOP:  begin o_cls = CL_NOP;  o_last = 3'd2; end
            OP_HALT: begin o_cls = CL_HALT; o_last = 3'd2; end
            default: begin o_cls = CL_ILL;  o_last = 3'd3; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer producing the one-hot control
// strobes of the single-bus datapath, one micro-step per clock.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned RST_PC_HOLD = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        ConOtp,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  OpCode,
    output logic        run,
    output logic        illegal
);

    localparam logic [1:0] HOLD_LAST = RST_PC_HOLD[1:0];

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_hold_cnt;
    logic [1:0]  w_hold_next;
    logic [4:0]  r_op;
    logic [4:0]  w_dec_op;
    iclass_t     w_cls;
    logic [2:0]  w_last;
    logic [3:0]  w_step_full;
    logic [2:0]  w_step;
    logic        w_unused;

    assign w_unused = ^ir[26:0];

    // The opcode is captured at the end of T2, so later IR changes cannot
    // disturb an instruction in flight; T2 itself decodes the live IR.
    assign w_dec_op    = (r_state == T2) ? ir[31:27] : r_op;
    assign w_step_full = r_state - 4'd1;
    assign w_step      = w_step_full[2:0];

    ctrl_decode u_decode (
        .i_op   (w_dec_op),
        .o_cls  (w_cls),
        .o_last (w_last)
    );

    // State, reset-hold counter and latched opcode.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= RST;
            r_hold_cnt <= 2'd0;
            r_op       <= OP_NOP;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_hold_next;
            r_op       <= (r_state == T2) ? ir[31:27] : r_op;
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next_state = r_state;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            RST: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = T0;
                    w_hold_next  = 2'd0;
                end else begin
                    w_hold_next  = r_hold_cnt + 2'd1;
                end
            end
            T0: w_next_state = T1;
            T1: w_next_state = T2;
            T2: begin
                if (w_cls == CL_HALT) begin
                    w_next_state = HALT;
                end else if (w_last == 3'd2) begin
                    w_next_state = T0;
                end else begin
                    w_next_state = T3;
                end
            end
            T3, T4, T5, T6, T7: begin
                if (w_step == w_last) begin
                    w_next_state = T0;
                end else begin
                    w_next_state = state_t'(r_state + 4'd1);
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = RST;
        endcase
    end

    // Control strobe decode from state and instruction class.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
        BAout = 1'b0; Rout = 1'b0; PCin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        Rin = 1'b0; CONin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Read = 1'b0; Write = 1'b0; OpCode = ALU_NOP;
        run = 1'b1; illegal = 1'b0;
        case (r_state)
            RST:  run = 1'b1;
            HALT: run = 1'b0;
            T0: begin PCout = 1'b1; MARin = 1'b1; OpCode = ALU_INC; Zin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                case (w_cls)
                    CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_RALU, CL_IALU:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_UNARY: begin Grb = 1'b1; Rout = 1'b1; OpCode = alu_sel(r_op); Zin = 1'b1; end
                    CL_BR:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    CL_JR:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    CL_ILL:   illegal = 1'b1;
                    default:  illegal = 1'b0;
                endcase
            end
            T4: begin
                case (w_cls)
                    CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1; OpCode = ALU_ADD; Zin = 1'b1; end
                    CL_RALU:  begin Grc = 1'b1; Rout = 1'b1; OpCode = alu_sel(r_op); Zin = 1'b1; end
                    CL_IALU:  begin Cout = 1'b1; OpCode = alu_sel(r_op); Zin = 1'b1; end
                    CL_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_BR:    begin PCout = 1'b1; Yin = 1'b1; end
                    default:  OpCode = ALU_NOP;
                endcase
            end
            T5: begin
                case (w_cls)
                    CL_LD, CL_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    CL_LDI, CL_RALU, CL_IALU: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_BR:   begin Cout = 1'b1; OpCode = ALU_ADD; Zin = 1'b1; end
                    default: OpCode = ALU_NOP;
                endcase
            end
            T6: begin
                case (w_cls)
                    CL_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CL_BR: begin
                        if (ConOtp) begin
                            Zlowout = 1'b1;
                            PCin    = 1'b1;
                        end else begin
                            Zlowout = 1'b0;
                            PCin    = 1'b0;
                        end
                    end
                    default: OpCode = ALU_NOP;
                endcase
            end
            T7: begin
                case (w_cls)
                    CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST:   Write = 1'b1;
                    default: OpCode = ALU_NOP;
                endcase
            end
            default: run = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a step-list reference model built from
// the instruction table, driven by directed and randomized instruction streams.
module tb_control_unit;

    localparam int HOLD = 0;

    localparam logic [19:0] M_PCOUT   = 20'h00001;
    localparam logic [19:0] M_ZLOWOUT = 20'h00002;
    localparam logic [19:0] M_MDROUT  = 20'h00004;
    localparam logic [19:0] M_COUT    = 20'h00008;
    localparam logic [19:0] M_BAOUT   = 20'h00010;
    localparam logic [19:0] M_ROUT    = 20'h00020;
    localparam logic [19:0] M_PCIN    = 20'h00040;
    localparam logic [19:0] M_MARIN   = 20'h00080;
    localparam logic [19:0] M_MDRIN   = 20'h00100;
    localparam logic [19:0] M_IRIN    = 20'h00200;
    localparam logic [19:0] M_YIN     = 20'h00400;
    localparam logic [19:0] M_ZIN     = 20'h00800;
    localparam logic [19:0] M_RIN     = 20'h01000;
    localparam logic [19:0] M_CONIN   = 20'h02000;
    localparam logic [19:0] M_GRA     = 20'h04000;
    localparam logic [19:0] M_GRB     = 20'h08000;
    localparam logic [19:0] M_GRC     = 20'h10000;
    localparam logic [19:0] M_READ    = 20'h20000;
    localparam logic [19:0] M_WRITE   = 20'h40000;
    localparam logic [19:0] M_ILLEGAL = 20'h80000;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        ConOtp;
    logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin;
    logic Gra, Grb, Grc, Read, Write, run, illegal;
    logic [4:0]  OpCode;
    logic [24:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int ill_seen = 0;
    logic [24:0] exp_q[$];

    control_unit #(.RST_PC_HOLD(HOLD)) dut (
        .clk(clk), .clr(clr), .ir(ir), .ConOtp(ConOtp),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
        .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read),
        .Write(Write), .OpCode(OpCode), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {OpCode, illegal, Write, Read, Grc, Grb, Gra, CONin, Rin, Zin,
                  Yin, IRin, MDRin, MARin, PCin, Rout, BAout, Cout, MDRout,
                  Zlowout, PCout};

    function automatic logic [24:0] mk(input logic [19:0] m, input logic [4:0] opc);
        return {opc, m};
    endfunction

    // ALU function codes the datapath expects for each ALU-using opcode.
    function automatic logic [4:0] ref_alu(input int op);
        case (op)
            3, 12:   return 5'd2;
            4:       return 5'd3;
            5, 13:   return 5'd1;
            6, 14:   return 5'd4;
            7:       return 5'd5;
            8:       return 5'd6;
            9:       return 5'd7;
            10:      return 5'd8;
            11:      return 5'd9;
            17:      return 5'd10;
            18:      return 5'd11;
            default: return 5'd0;
        endcase
    endfunction

    // Expected per-cycle strobes for one whole instruction, fetch included.
    task automatic build_prog(input int op, input logic con);
        exp_q.delete();
        exp_q.push_back(mk(M_PCOUT | M_MARIN | M_ZIN, 5'd12));
        exp_q.push_back(mk(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0));
        exp_q.push_back(mk(M_MDROUT | M_IRIN, 5'd0));
        if (op <= 2) begin
            exp_q.push_back(mk(M_GRB | M_ROUT | M_BAOUT | M_YIN, 5'd0));
            exp_q.push_back(mk(M_COUT | M_ZIN, 5'd2));
            if (op == 1) begin
                exp_q.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
            end else begin
                exp_q.push_back(mk(M_ZLOWOUT | M_MARIN, 5'd0));
                if (op == 0) begin
                    exp_q.push_back(mk(M_READ | M_MDRIN, 5'd0));
                    exp_q.push_back(mk(M_MDROUT | M_GRA | M_RIN, 5'd0));
                end else begin
                    exp_q.push_back(mk(M_GRA | M_ROUT | M_MDRIN, 5'd0));
                    exp_q.push_back(mk(M_WRITE, 5'd0));
                end
            end
        end else if (op <= 14) begin
            exp_q.push_back(mk(M_GRB | M_ROUT | M_YIN, 5'd0));
            if (op <= 11) exp_q.push_back(mk(M_GRC | M_ROUT | M_ZIN, ref_alu(op)));
            else          exp_q.push_back(mk(M_COUT | M_ZIN, ref_alu(op)));
            exp_q.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        end else if (op == 17 || op == 18) begin
            exp_q.push_back(mk(M_GRB | M_ROUT | M_ZIN, ref_alu(op)));
            exp_q.push_back(mk(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        end else if (op == 19) begin
            exp_q.push_back(mk(M_GRA | M_ROUT | M_CONIN, 5'd0));
            exp_q.push_back(mk(M_PCOUT | M_YIN, 5'd0));
            exp_q.push_back(mk(M_COUT | M_ZIN, 5'd2));
            exp_q.push_back(mk(con ? (M_ZLOWOUT | M_PCIN) : 20'h00000, 5'd0));
        end else if (op == 20) begin
            exp_q.push_back(mk(M_GRA | M_ROUT | M_PCIN, 5'd0));
        end else if (op != 26 && op != 27) begin
            exp_q.push_back(mk(M_ILLEGAL, 5'd0));
        end
    endtask

    // Runs one instruction from T0; IR is valid only in T2, ConOtp only in T6.
    // abort_at >= 0 pulls clr low during that step and checks the reset entry.
    task automatic run_instr(input logic [31:0] ir_val, input logic con, input int abort_at);
        int op;
        int drv;
        op = int'(ir_val[31:27]);
        build_prog(op, con);
        for (int i = 0; i < exp_q.size(); i++) begin
            ir     = (i == 2) ? ir_val : $urandom();
            ConOtp = (i == 6) ? con : 1'($urandom_range(0, 1));
            #1;
            drv = int'(PCout) + int'(Zlowout) + int'(MDRout) + int'(Cout) + int'(Rout | BAout);
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL strobes op=%0d T%0d: got %h expected %h", op, i, obs, exp_q[i]);
            end
            n_checks++;
            if (run !== 1'b1) begin
                n_fail++;
                $display("FAIL run op=%0d T%0d: got %b expected 1", op, i, run);
            end
            n_checks++;
            if (drv > 1) begin
                n_fail++;
                $display("FAIL single_driver op=%0d T%0d: got %0d drivers expected <=1", op, i, drv);
            end
            if (illegal === 1'b1) ill_seen++;
            if (i == abort_at) begin
                clr = 1'b0;
                @(posedge clk); #1;
                clr = 1'b1;
                n_checks++;
                if (obs !== 25'd0 || run !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_rst: got strobes %h run %b expected 0 run 1", obs, run);
                end
                for (int h = 0; h < HOLD; h++) begin
                    @(posedge clk); #1;
                end
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        clr = 1'b0; ir = 32'h0; ConOtp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        n_checks++;
        if (obs !== 25'd0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got strobes %h run %b expected 0 run 1", obs, run);
        end
        for (int h = 0; h < HOLD; h++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        run_instr(32'hD000_0000, 1'b0, -1);
    endtask

    task automatic test_branch;
        run_instr(32'h9B00_0019, 1'b1, -1);
        run_instr(32'h9B00_0019, 1'b0, -1);
    endtask

    task automatic test_load;
        run_instr(32'h0080_0055, 1'b0, -1);
        run_instr(32'h1080_0055, 1'b0, -1);
        run_instr(32'h0880_0055, 1'b0, -1);
    endtask

    task automatic test_alu;
        run_instr(32'h1989_0000, 1'b0, -1);
        for (int op = 3; op <= 20; op++) begin
            run_instr({5'(op), 27'($urandom())}, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    task automatic test_illegal;
        ill_seen = 0;
        run_instr(32'hF800_0000, 1'b0, -1);
        n_checks++;
        if (ill_seen != 1) begin
            n_fail++;
            $display("FAIL illegal_pulses: got %0d expected 1", ill_seen);
        end
        run_instr(32'hD000_0000, 1'b0, -1);
    endtask

    task automatic test_reset_mid;
        run_instr(32'h0080_0055, 1'b0, 5);
        run_instr(32'h1989_0000, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        logic [4:0] op;
        for (int k = 0; k < 60; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr({op, 27'($urandom())}, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    task automatic test_halt;
        run_instr(32'hD800_0000, 1'b0, -1);
        for (int c = 0; c < 20; c++) begin
            ir     = $urandom();
            ConOtp = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (obs !== 25'd0 || run !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold cycle %0d: got strobes %h run %b expected 0 run 0", c, obs, run);
            end
            @(posedge clk); #1;
        end
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        n_checks++;
        if (obs !== 25'd0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_exit_rst: got strobes %h run %b expected 0 run 1", obs, run);
        end
        for (int h = 0; h < HOLD; h++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        run_instr(32'hD000_0000, 1'b0, -1);
    endtask

    initial begin
        test_reset;
        test_branch;
        test_load;
        test_alu;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        test_halt;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
